// File: rtl/mem_cmd_responder.sv
// Synthesizable memory-side responder for the command bus: decodes commands, tracks
// open rows per bank, stores write bursts, returns read bursts and flags protocol errors.
module mem_cmd_responder #(
  parameter int unsigned BA_WIDTH   = 2,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned COL_BITS   = 4,
  parameter int unsigned SROW_BITS  = 2,
  parameter int unsigned DQ_WIDTH   = 16,
  parameter int unsigned DM_WIDTH   = 2,
  parameter int unsigned CAS_LAT    = 3,
  parameter int unsigned WR_LAT     = 1,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  cs_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [BA_WIDTH-1:0]   ba,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DQ_WIDTH-1:0]   dq_in,
  input  logic [DM_WIDTH-1:0]   dm,
  output logic [DQ_WIDTH-1:0]   dq_out,
  output logic                  dq_oe,
  output logic                  qvld,
  output logic                  err,
  output logic [2:0]            err_code,
  output logic [15:0]           rd_cnt,
  output logic [15:0]           wr_cnt
);

  localparam int unsigned NUM_BANKS = 1 << BA_WIDTH;
  localparam int unsigned IDX_W     = BA_WIDTH + SROW_BITS + COL_BITS;
  localparam int unsigned DEPTH     = 1 << IDX_W;
  localparam int unsigned BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned MAX_LAT   = (CAS_LAT > WR_LAT) ? CAS_LAT : WR_LAT;
  localparam int unsigned WIN_W     = MAX_LAT + BURST_LEN;
  localparam int unsigned GAP_W     = $clog2(BURST_LEN + 1);

  localparam logic [WIN_W-1:0]    BURST_MASK = WIN_W'((64'd1 << BURST_LEN) - 64'd1);
  localparam logic [WIN_W-1:0]    RD_WIN     = BURST_MASK << CAS_LAT;
  localparam logic [WIN_W-1:0]    WR_WIN     = BURST_MASK << WR_LAT;
  localparam logic [COL_BITS-1:0] BEAT_MASK  = COL_BITS'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0]    GAP_MIN    = GAP_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0]   BEAT_LAST  = BEAT_W'(BURST_LEN - 1);

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_CLOSED   = 3'd1;
  localparam logic [2:0] ERR_ACT_OPEN = 3'd2;
  localparam logic [2:0] ERR_REF_OPEN = 3'd3;
  localparam logic [2:0] ERR_SPACING  = 3'd4;
  localparam logic [2:0] ERR_WR_BUS   = 3'd5;
  localparam logic [2:0] ERR_RD_BUS   = 3'd6;

  typedef enum logic [2:0] {
    CMD_MRS  = 3'b000,
    CMD_REF  = 3'b001,
    CMD_PRE  = 3'b010,
    CMD_ACT  = 3'b011,
    CMD_WR   = 3'b100,
    CMD_RD   = 3'b101,
    CMD_RSVD = 3'b110,
    CMD_NOP  = 3'b111
  } cmd_e;

  typedef struct packed {
    logic [BA_WIDTH-1:0]  ba;
    logic [SROW_BITS-1:0] row;
    logic [COL_BITS-1:0]  col;
  } req_t;

  // Column of beat k, wrapping inside the aligned burst.
  function automatic logic [COL_BITS-1:0] beat_col(input logic [COL_BITS-1:0] col,
                                                   input logic [BEAT_W-1:0]   beat);
    return (col & ~BEAT_MASK) | ((col + COL_BITS'(beat)) & BEAT_MASK);
  endfunction

  logic [DQ_WIDTH-1:0]  mem [DEPTH];
  logic [NUM_BANKS-1:0] bank_open;
  logic [SROW_BITS-1:0] bank_row [NUM_BANKS];
  logic [GAP_W-1:0]     gap;
  logic [WIN_W-1:0]     rd_busy;
  logic [WIN_W-1:0]     wr_busy;

  logic [CAS_LAT-1:0]   rd_pipe_vld;
  req_t                 rd_pipe [CAS_LAT];
  logic                 rd_act;
  logic [BEAT_W-1:0]    rd_beat;
  req_t                 rd_req;
  logic                 wr_act;
  logic [BEAT_W-1:0]    wr_beat;
  logic                 wr_act_q;
  req_t                 wr_req;

  cmd_e                 cmd_c;
  logic                 cmd_vld_c, is_act_c, is_rd_c, is_wr_c, is_pre_c, is_ref_c;
  logic [2:0]           err_c;
  logic                 act_ok_c, rd_ok_c, wr_ok_c;
  req_t                 cmd_req_c;
  logic                 rd_beat_vld_c, wr_beat_vld_c, rd_last_c, wr_last_c;
  req_t                 rd_cur_req_c, wr_cur_req_c, wr_start_req_c;
  logic [BEAT_W-1:0]    rd_cur_beat_c, wr_cur_beat_c;
  logic                 wr_start_c;
  logic [IDX_W-1:0]     rd_idx_c, wr_idx_c;
  logic                 unused_c;

  assign unused_c = ^addr;
  assign wr_act   = wr_act_q;

  // Decode and error classification; only one command per cycle so the chain is the priority.
  always_comb begin
    cmd_c     = cmd_e'({ras_n, cas_n, we_n});
    cmd_vld_c = clk_en & ~cs_n;
    is_act_c  = cmd_vld_c && (cmd_c == CMD_ACT);
    is_rd_c   = cmd_vld_c && (cmd_c == CMD_RD);
    is_wr_c   = cmd_vld_c && (cmd_c == CMD_WR);
    is_pre_c  = cmd_vld_c && (cmd_c == CMD_PRE);
    is_ref_c  = cmd_vld_c && (cmd_c == CMD_REF);
    err_c     = ERR_NONE;
    if ((is_rd_c || is_wr_c) && !bank_open[ba])            err_c = ERR_CLOSED;
    else if (is_act_c && bank_open[ba])                    err_c = ERR_ACT_OPEN;
    else if (is_ref_c && (|bank_open))                     err_c = ERR_REF_OPEN;
    else if ((is_rd_c || is_wr_c) && (gap < GAP_MIN))      err_c = ERR_SPACING;
    else if (is_wr_c && (|(WR_WIN & rd_busy)))             err_c = ERR_WR_BUS;
    else if (is_rd_c && (|(RD_WIN & wr_busy)))             err_c = ERR_RD_BUS;
    act_ok_c  = is_act_c && (err_c == ERR_NONE);
    rd_ok_c   = is_rd_c && (err_c == ERR_NONE);
    wr_ok_c   = is_wr_c && (err_c == ERR_NONE);
    cmd_req_c = '{ba: ba, row: bank_row[ba], col: addr[COL_BITS-1:0]};
  end

  generate
    if (WR_LAT == 0) begin : g_wr_nodly
      assign wr_start_c     = wr_ok_c;
      assign wr_start_req_c = cmd_req_c;
    end else begin : g_wr_dly
      logic [WR_LAT-1:0] vld;
      req_t              pipe [WR_LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= '0;
          for (int i = 0; i < WR_LAT; i++) pipe[i] <= '0;
        end else begin
          vld[0]  <= wr_ok_c;
          pipe[0] <= cmd_req_c;
          for (int i = 1; i < WR_LAT; i++) begin
            vld[i]  <= vld[i-1];
            pipe[i] <= pipe[i-1];
          end
        end
      end
      assign wr_start_c     = vld[WR_LAT-1];
      assign wr_start_req_c = pipe[WR_LAT-1];
    end
  endgenerate

  // Beat engines: a delayed request supplies beat 0, the engine register supplies the rest.
  always_comb begin
    rd_beat_vld_c = rd_act | rd_pipe_vld[CAS_LAT-1];
    rd_cur_req_c  = rd_act ? rd_req : rd_pipe[CAS_LAT-1];
    rd_cur_beat_c = rd_act ? rd_beat : '0;
    rd_last_c     = (rd_cur_beat_c == BEAT_LAST);
    rd_idx_c      = {rd_cur_req_c.ba, rd_cur_req_c.row, beat_col(rd_cur_req_c.col, rd_cur_beat_c)};
    wr_beat_vld_c = wr_act | wr_start_c;
    wr_cur_req_c  = wr_act ? wr_req : wr_start_req_c;
    wr_cur_beat_c = wr_act ? wr_beat : '0;
    wr_last_c     = (wr_cur_beat_c == BEAT_LAST);
    wr_idx_c      = {wr_cur_req_c.ba, wr_cur_req_c.row, beat_col(wr_cur_req_c.col, wr_cur_beat_c)};
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_beat_vld_c) begin
      for (int b = 0; b < DM_WIDTH; b++) begin
        if (!dm[b]) mem[wr_idx_c][8*b +: 8] <= dq_in[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_open   <= '0;
      for (int i = 0; i < NUM_BANKS; i++) bank_row[i] <= '0;
      gap         <= GAP_MIN;
      rd_busy     <= '0;
      wr_busy     <= '0;
      rd_pipe_vld <= '0;
      for (int i = 0; i < CAS_LAT; i++) rd_pipe[i] <= '0;
      rd_act      <= 1'b0;
      rd_beat     <= '0;
      rd_req      <= '0;
      wr_act_q    <= 1'b0;
      wr_beat     <= '0;
      wr_req      <= '0;
      dq_out      <= '0;
      dq_oe       <= 1'b0;
      qvld        <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
    end else begin
      if (act_ok_c) begin
        bank_open[ba] <= 1'b1;
        bank_row[ba]  <= addr[SROW_BITS-1:0];
      end else if (is_pre_c) begin
        if (addr[10]) bank_open <= '0;
        else          bank_open[ba] <= 1'b0;
      end

      if (rd_ok_c || wr_ok_c) gap <= GAP_W'(1);
      else if (gap < GAP_MIN) gap <= gap + GAP_W'(1);

      // Occupancy maps: bit j = data beat on the (j+1)th edge from now.
      rd_busy <= (rd_busy >> 1) | (rd_ok_c ? (RD_WIN >> 1) : '0);
      wr_busy <= (wr_busy >> 1) | (wr_ok_c ? (WR_WIN >> 1) : '0);

      rd_pipe_vld <= {rd_pipe_vld[CAS_LAT-2:0], rd_ok_c};
      rd_pipe[0]  <= cmd_req_c;
      for (int i = 1; i < CAS_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];

      if (rd_beat_vld_c) begin
        dq_out <= mem[rd_idx_c];
        dq_oe  <= 1'b1;
        qvld   <= 1'b1;
        if (rd_last_c) begin
          rd_act <= 1'b0;
          rd_cnt <= rd_cnt + 16'd1;
        end else begin
          rd_act  <= 1'b1;
          rd_beat <= rd_cur_beat_c + BEAT_W'(1);
          rd_req  <= rd_cur_req_c;
        end
      end else begin
        dq_out <= '0;
        dq_oe  <= 1'b0;
        qvld   <= 1'b0;
      end

      if (wr_beat_vld_c) begin
        if (wr_last_c) begin
          wr_act_q <= 1'b0;
          wr_cnt   <= wr_cnt + 16'd1;
        end else begin
          wr_act_q <= 1'b1;
          wr_beat  <= wr_cur_beat_c + BEAT_W'(1);
          wr_req   <= wr_cur_req_c;
        end
      end

      if (!err && (err_c != ERR_NONE)) begin
        err      <= 1'b1;
        err_code <= err_c;
      end
    end
  end

endmodule
